// File: rtl/config_access_pkg.sv
// Shared types and helpers for the config-bit export shadow and its serial readback.
package config_access_pkg;

    typedef enum logic {
        RB_IDLE  = 1'b0,
        RB_SHIFT = 1'b1
    } rb_state_t;

    localparam int UPD_TRANSPARENT = 0;
    localparam int UPD_STROBE      = 1;

    // Ceiling log2, never below 1 so it can size a counter directly.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/config_readback_shifter.sv
// Serial readback engine: captures a frame on start and emits it LSB first, one bit per cycle.
// Handshake: valid qualifies data for one cycle per bit; busy equals valid; start is taken in IDLE
// or on the last bit of a frame (back-to-back), and ignored otherwise.
module config_readback_shifter
    import config_access_pkg::*;
#(
    parameter int FrameWidth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FrameWidth-1:0] snapshot,
    input  logic                  start,
    output logic                  busy,
    output logic                  data,
    output logic                  valid,
    output rb_state_t             state
);

    localparam int CntW = clog2(FrameWidth + 1);

    rb_state_t             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [FrameWidth-1:0] sr_q, sr_d;
    logic                  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RB_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q;
        load    = 1'b0;
        case (state_q)
            RB_IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            RB_SHIFT: begin
                // cnt counts bits already presented; at FrameWidth the last bit is on the wire.
                if (cnt_q == CntW'(FrameWidth)) begin
                    if (start) begin
                        load = 1'b1;
                    end else begin
                        state_d = RB_IDLE;
                        cnt_d   = '0;
                        data_d  = 1'b0;
                        valid_d = 1'b0;
                    end
                end else begin
                    data_d = sr_q[0];
                    sr_d   = sr_q >> 1;
                    cnt_d  = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = RB_IDLE;
            end
        endcase
        // Bit 0 goes straight to the output register so the first valid bit follows start by one cycle.
        if (load) begin
            state_d = RB_SHIFT;
            sr_d    = snapshot >> 1;
            data_d  = snapshot[0];
            cnt_d   = CntW'(1);
            valid_d = 1'b1;
        end
    end

    assign busy  = (state_q == RB_SHIFT);
    assign data  = data_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule

// File: rtl/config_access_shadow.sv
// Registered export shadow of a config-latch field with change pulse and serial readback.
// Optional CONFIG_ACCESS_PARITY_EN adds C_parity and appends the parity bit to each readback frame.
module config_access_shadow
    import config_access_pkg::*;
#(
    parameter int NoConfigBits = 4,
    parameter int UpdateMode   = UPD_TRANSPARENT
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NoConfigBits-1:0] ConfigBits,
    input  logic                    Update,
    output logic [NoConfigBits-1:0] C_bit,
    output logic                    Changed,
`ifdef CONFIG_ACCESS_PARITY_EN
    output logic                    C_parity,
`endif
    input  logic                    RB_Start,
    output logic                    RB_Busy,
    output logic                    RB_Data,
    output logic                    RB_Valid
);

`ifdef CONFIG_ACCESS_PARITY_EN
    localparam int FrameWidth = NoConfigBits + 1;
`else
    localparam int FrameWidth = NoConfigBits;
`endif

    logic                  load;
    logic [FrameWidth-1:0] snapshot;
    rb_state_t             rb_state;

    assign load = (UpdateMode == UPD_TRANSPARENT) || Update;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            C_bit   <= '0;
            Changed <= 1'b0;
        end else if (load) begin
            C_bit   <= ConfigBits;
            Changed <= (ConfigBits != C_bit);
        end else begin
            Changed <= 1'b0;
        end
    end

`ifdef CONFIG_ACCESS_PARITY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            C_parity <= 1'b0;
        end else if (load) begin
            C_parity <= ^ConfigBits;
        end
    end

    assign snapshot = {^C_bit, C_bit};
`else
    assign snapshot = C_bit;
`endif

    // The shifter samples the shadow as it stood before the edge, so a same-edge load cannot leak in.
    config_readback_shifter #(
        .FrameWidth(FrameWidth)
    ) u_shifter (
        .clk     (CLK),
        .rst     (RST),
        .snapshot(snapshot),
        .start   (RB_Start),
        .busy    (RB_Busy),
        .data    (RB_Data),
        .valid   (RB_Valid),
        .state   (rb_state)
    );

    busy_tracks_state: assert property (@(posedge CLK) disable iff (RST) RB_Busy == (rb_state == RB_SHIFT));

endmodule
